// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and helpers for the edge event arbiter.
`default_nettype none

package edge_evt_pkg;

  localparam int MAX_CH = 16;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic int next_idx(input int cur, input int n);
    return (cur + 1) % n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_event_arbiter_if.sv
// Valid/ready event stream carrying channel index and edge direction.
`default_nettype none

interface edge_event_arbiter_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_rise;

  modport master (output evt_valid, output evt_ch, output evt_rise, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, input evt_rise, output evt_ready);
endinterface

`default_nettype wire

// File: rtl/edge_event_channel.sv
// One input channel: optional synchroniser (SYNC2_EN), edge detect, mode mask, pending/type latch, sticky overflow.
`default_nettype none

module edge_event_channel
  import edge_evt_pkg::*;
(
  input  wire logic       clock,
  input  wire logic       rst_n,
  input  wire logic       sig,
  input  wire edge_mode_t mode,
  input  wire logic       armed,
  input  wire logic       grant,
  input  wire logic       clr_overflow,
  output logic            pending,
  output logic            ptype,
  output logic            overflow
);

  logic s;
  logic d_q;
  logic rise;
  logic fall;
  logic counted;
  logic drop;

`ifdef SYNC2_EN
  logic [1:0] sync_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], sig};
  end

  assign s = sync_q[1];
`else
  assign s = sig;
`endif

  assign rise    = armed & ~d_q & s;
  assign fall    = armed & d_q & ~s;
  assign counted = (((mode == EDGE_RISE) || (mode == EDGE_BOTH)) & rise)
                 | (((mode == EDGE_FALL) || (mode == EDGE_BOTH)) & fall);
  // A grant in the same cycle frees the slot, so the new edge reloads instead of dropping.
  assign drop    = counted & pending & ~grant;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      d_q      <= 1'b0;
      pending  <= 1'b0;
      ptype    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      d_q <= s;
      if (mode == EDGE_OFF) begin
        pending <= 1'b0;
      end else if (counted && (!pending || grant)) begin
        pending <= 1'b1;
        ptype   <= rise;
      end else if (grant) begin
        pending <= 1'b0;
      end
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/edge_event_arbiter.sv
// Edge event arbiter top: per-channel detectors, round-robin pick, IDLE/HOLD output stage.
// Optional 2-flop input synchronisers enabled by defining SYNC2_EN.
`default_nettype none

module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  wire logic                  clock,
  input  wire logic                  rst_n,
  input  wire logic [NUM_CH-1:0]     signal,
  input  wire logic [2*NUM_CH-1:0]   mode_cfg,
  output logic      [NUM_CH-1:0]     overflow,
  input  wire logic                  clr_overflow,
  edge_event_arbiter_if.master       evt
);

  localparam int CH_W = $clog2(NUM_CH);

`ifdef SYNC2_EN
  localparam logic [1:0] ARM_CYC = 2'd3;
`else
  localparam logic [1:0] ARM_CYC = 2'd1;
`endif

  logic [1:0]        arm_cnt;
  logic              armed;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] ptype;
  logic [NUM_CH-1:0] grant;
  state_t            state, state_nxt;
  logic [CH_W-1:0]   rr_ptr, rr_nxt;
  logic [CH_W-1:0]   pick;
  logic [CH_W-1:0]   ch_q, ch_nxt;
  logic              rise_q, rise_nxt;
  logic              found;
  logic              take;

  // Arming hides levels already present at reset exit (including synchroniser fill).
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                 arm_cnt <= 2'd0;
    else if (arm_cnt < ARM_CYC) arm_cnt <= arm_cnt + 2'd1;
  end

  assign armed = (arm_cnt == ARM_CYC);

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      edge_event_channel u_ch (
        .clock        (clock),
        .rst_n        (rst_n),
        .sig          (signal[i]),
        .mode         (edge_mode_t'(mode_cfg[2*i +: 2])),
        .armed        (armed),
        .grant        (grant[i]),
        .clr_overflow (clr_overflow),
        .pending      (pending[i]),
        .ptype        (ptype[i]),
        .overflow     (overflow[i])
      );
    end
  endgenerate

  always_comb begin : rr_pick
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CH;
      if (!found && pending[idx]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
  end

  always_comb begin : fsm_next
    state_nxt = state;
    ch_nxt    = ch_q;
    rise_nxt  = rise_q;
    rr_nxt    = rr_ptr;
    grant     = '0;
    // In HOLD evt_valid is 1, so evt_ready alone completes the handshake.
    take      = (state == ST_IDLE) || evt.evt_ready;
    if (take) begin
      if (found) begin
        state_nxt   = ST_HOLD;
        grant[pick] = 1'b1;
        ch_nxt      = pick;
        rise_nxt    = ptype[pick];
        rr_nxt      = CH_W'(next_idx(int'(pick), NUM_CH));
      end else begin
        state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ch_q   <= '0;
      rise_q <= 1'b0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      ch_q   <= ch_nxt;
      rise_q <= rise_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  assign evt.evt_valid = (state == ST_HOLD);
  assign evt.evt_ch    = ch_q;
  assign evt.evt_rise  = rise_q;

endmodule

`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench: directed vectors, cycle-level reference model, literal expectations.
`default_nettype none

module tb_edge_event_arbiter;
  import edge_evt_pkg::*;

  localparam int N  = 4;
  localparam int CW = $clog2(N);
`ifdef SYNC2_EN
  localparam int SLAT = 2;
  localparam int ARM  = 3;
`else
  localparam int SLAT = 0;
  localparam int ARM  = 1;
`endif

  logic           clock        = 1'b0;
  logic           rst_n        = 1'b0;
  logic [N-1:0]   signal       = '0;
  logic [2*N-1:0] mode_cfg     = '0;
  logic           clr_overflow = 1'b0;
  logic [N-1:0]   overflow;

  edge_event_arbiter_if #(.NUM_CH(N)) evt ();

  edge_event_arbiter #(.NUM_CH(N)) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .signal       (signal),
    .mode_cfg     (mode_cfg),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .evt          (evt.master)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;
  int log_q[$];
  int exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk_log(input string nm);
    chk({nm, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk({nm, "_entry"}, log_q[i], exp_q[i]);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset(input logic [N-1:0] sig, input logic [2*N-1:0] md);
    rst_n    = 1'b0;
    signal   = sig;
    mode_cfg = md;
    tick(2);
    log_q.delete();
    rst_n = 1'b1;
    tick(ARM + 3);
  endtask

  // Reference model: what the event stream must show, cycle by cycle.
  logic [N-1:0] m_pend, m_type, m_ov, m_prev, m_s1, m_s2;
  int           m_arm, m_rr, m_ch;
  logic         m_valid, m_rise;

  always @(posedge clock or negedge rst_n) begin : model
    logic [N-1:0] p, t, ovs, s;
    logic [1:0]   md;
    logic         ri, fa, cnt, take;
    int           g;
    if (!rst_n) begin
      m_pend <= '0; m_type <= '0; m_ov <= '0; m_prev <= '0; m_s1 <= '0; m_s2 <= '0;
      m_arm <= 0; m_rr <= 0; m_ch <= 0; m_valid <= 1'b0; m_rise <= 1'b0;
    end else begin
      p   = m_pend;
      t   = m_type;
      ovs = '0;
      s   = (SLAT != 0) ? m_s2 : signal;
      g   = -1;
      take = !m_valid || evt.evt_ready;
      if (take)
        for (int k = 0; k < N; k++)
          if (g < 0 && p[(m_rr + k) % N]) g = (m_rr + k) % N;
      if (take) begin
        if (g >= 0) begin
          m_valid <= 1'b1; m_ch <= g; m_rise <= t[g]; m_rr <= (g + 1) % N;
        end else begin
          m_valid <= 1'b0;
        end
      end
      for (int c = 0; c < N; c++) begin
        md  = mode_cfg[2*c +: 2];
        ri  = !m_prev[c] && s[c];
        fa  = m_prev[c] && !s[c];
        cnt = (m_arm >= ARM) && ((md[0] && ri) || (md[1] && fa));
        if (md == 2'b00) p[c] = 1'b0;
        else if (cnt) begin
          if (!p[c] || c == g) begin p[c] = 1'b1; t[c] = ri; end
          else ovs[c] = 1'b1;
        end else if (c == g) p[c] = 1'b0;
      end
      m_pend <= p;
      m_type <= t;
      m_ov   <= (m_ov & ~{N{clr_overflow}}) | ovs;
      m_prev <= s;
      m_s1   <= signal;
      m_s2   <= m_s1;
      if (m_arm < ARM) m_arm <= m_arm + 1;
    end
  end

  always @(negedge clock) begin
    chk("model_valid", evt.evt_valid, m_valid);
    if (m_valid) begin
      chk("model_ch", evt.evt_ch, m_ch[CW-1:0]);
      chk("model_rise", evt.evt_rise, m_rise);
    end
    chk("model_overflow", overflow, m_ov);
    if (rst_n && evt.evt_valid && evt.evt_ready)
      log_q.push_back(int'(evt.evt_ch) * 2 + int'(evt.evt_rise));
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    evt.evt_ready = 1'b1;

    // Reset state
    tick(2);
    chk("rst_valid", evt.evt_valid, 0);
    chk("rst_ch", evt.evt_ch, 0);
    chk("rst_rise", evt.evt_rise, 0);
    chk("rst_overflow", overflow, 0);

    // 1: levels high at reset exit raise nothing
    do_reset(4'b1111, 8'hFF);
    tick(10);
    exp_q = {};
    chk_log("t1_log");
    chk("t1_overflow", overflow, 0);

    // 2: single rise on ch2, latency and one-cycle valid
    do_reset(4'b0000, 8'b00_01_00_00);
    signal[2] = 1'b1;
    lat = 0;
    while (!evt.evt_valid && lat < 12) begin
      tick(1);
      lat++;
    end
    chk("t2_latency", lat, 2 + SLAT);
    chk("t2_ch", evt.evt_ch, 2);
    chk("t2_rise", evt.evt_rise, 1);
    tick(1);
    chk("t2_valid_drop", evt.evt_valid, 0);
    exp_q = {5};
    chk_log("t2_log");

    // 3: simultaneous rises on ch0/1/3, then prove rr wrapped back to 0
    do_reset(4'b0000, 8'b01_01_01_01);
    signal = 4'b1011;
    tick(6 + SLAT);
    exp_q = {1, 3, 7};
    chk_log("t3_log");
    signal = 4'b0000;
    tick(4 + SLAT);
    log_q.delete();
    signal = 4'b1001;
    tick(6 + SLAT);
    exp_q = {1, 7};
    chk_log("t3_rr_log");

    // 4: falls on ch1 with consumer stalled -> held event, then overflow
    do_reset(4'b0010, 8'b00_00_10_00);
    evt.evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      signal[1] = ~signal[1];
      tick(2);
    end
    tick(2 + SLAT);
    chk("t4_valid", evt.evt_valid, 1);
    chk("t4_ch", evt.evt_ch, 1);
    chk("t4_rise", evt.evt_rise, 0);
    chk("t4_overflow", overflow, 4'b0010);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    tick(1);
    chk("t4_overflow_clr", overflow, 0);
    log_q.delete();
    evt.evt_ready = 1'b1;
    tick(4);
    exp_q = {2, 2};
    chk_log("t4_drain_log");

    // 5: async reset during HOLD drops the event and all pending
    do_reset(4'b0000, 8'b01_00_00_01);
    evt.evt_ready = 1'b0;
    signal = 4'b1000;
    tick(3 + SLAT);
    signal = 4'b1001;
    tick(3 + SLAT);
    chk("t5_hold_valid", evt.evt_valid, 1);
    chk("t5_hold_ch", evt.evt_ch, 3);
    mode_cfg = 8'b00_00_00_01;
    tick(1);
    #1 rst_n = 1'b0;
    #1 chk("t5_async_valid", evt.evt_valid, 0);
    chk("t5_async_ch", evt.evt_ch, 0);
    tick(2);
    evt.evt_ready = 1'b1;
    log_q.delete();
    rst_n = 1'b1;
    tick(10);
    exp_q = {};
    chk_log("t5_after_log");

    // 6: toggling ch0 in both mode -> alternating events, no overflow
    do_reset(4'b0000, 8'b00_00_00_11);
    for (int i = 0; i < 8; i++) begin
      signal[0] = ~signal[0];
      tick(1);
    end
    tick(6);
    exp_q = {1, 0, 1, 0, 1, 0, 1, 0};
    chk_log("t6_log");
    chk("t6_overflow", overflow, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
